// File: rtl/fetch_queue.sv
// Instruction fetch queue: credit-limited request issue, in-order response queue, redirect flush.
// Optional same-cycle response bypass to the core when FETCH_QUEUE_BYPASS_EN is defined.
module fetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   input  logic        halt,
   output logic        imem_req_valid,
   output logic [31:0] imem_req_addr,
   input  logic        imem_req_ready,
   input  logic        imem_resp_valid,
   input  logic [31:0] imem_resp_data,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

   typedef enum logic {FETCH, HALTED} state_t;

   state_t        state, state_next;
   logic [31:0]   fetch_pc, resp_pc;
   logic [CW-1:0] occupancy, in_flight, drop_count;
   logic [AW-1:0] head, tail;
   logic [31:0]   q_data [DEPTH];
   logic [31:0]   q_pc   [DEPTH];

   logic          req_fire, resp_live, resp_drop, resp_keep;
   logic          bypass, push, pop, q_pop;
   logic [CW:0]   credit_sum;

   always_comb begin
      state_next = state;
      if (redirect_valid)
         state_next = FETCH;
      else if (state == FETCH && halt)
         state_next = HALTED;
   end

   always_comb begin
      credit_sum     = {1'b0, occupancy} + {1'b0, in_flight};
      imem_req_valid = !reset && (state == FETCH) && !redirect_valid && (credit_sum < DEPTH_W);
      imem_req_addr  = reset ? RESET_PC : fetch_pc;
      req_fire       = imem_req_valid && imem_req_ready;

      // Responses with nothing outstanding are spurious and never touch the counters.
      resp_live = !reset && imem_resp_valid && (in_flight != '0);
      resp_drop = resp_live && (drop_count != '0);
      resp_keep = resp_live && (drop_count == '0) && !redirect_valid;

`ifdef FETCH_QUEUE_BYPASS_EN
      bypass = resp_keep && (occupancy == '0);
`else
      bypass = 1'b0;
`endif

      inst_valid = !reset && ((occupancy != '0) || bypass);
      inst       = '0;
      inst_pc    = '0;
      if (!reset) begin
`ifdef FETCH_QUEUE_BYPASS_EN
         if (occupancy == '0) begin
            inst    = imem_resp_data;
            inst_pc = resp_pc;
         end else begin
            inst    = q_data[head];
            inst_pc = q_pc[head];
         end
`else
         inst    = q_data[head];
         inst_pc = q_pc[head];
`endif
      end

      pop   = inst_valid && inst_ready && !redirect_valid;
      q_pop = pop && (occupancy != '0);
      // A bypassed word taken by the core the same cycle never occupies a slot.
      push  = resp_keep && !(bypass && inst_ready);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= FETCH;
         fetch_pc   <= RESET_PC;
         resp_pc    <= RESET_PC;
         occupancy  <= '0;
         in_flight  <= '0;
         drop_count <= '0;
         head       <= '0;
         tail       <= '0;
      end else begin
         state     <= state_next;
         in_flight <= in_flight + CW'(req_fire) - CW'(resp_live);
         if (redirect_valid) begin
            fetch_pc   <= redirect_pc;
            resp_pc    <= redirect_pc;
            occupancy  <= '0;
            head       <= '0;
            tail       <= '0;
            drop_count <= in_flight - CW'(resp_live);
         end else begin
            if (req_fire)
               fetch_pc <= fetch_pc + 32'd4;
            if (resp_drop)
               drop_count <= drop_count - 1'b1;
            if (resp_keep)
               resp_pc <= resp_pc + 32'd4;
            if (push)
               tail <= tail + 1'b1;
            if (q_pop)
               head <= head + 1'b1;
            occupancy <= occupancy + CW'(push) - CW'(q_pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         q_data[tail] <= imem_resp_data;
         q_pc[tail]   <= resp_pc;
      end
   end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: memory model with configurable latency and a queue-based reference.
module tb_fetch_queue;

   localparam int unsigned DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0;
`ifdef FETCH_QUEUE_BYPASS_EN
   localparam int BYP = 1;
`else
   localparam int BYP = 0;
`endif

   logic        clk;
   logic        reset;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        halt;
   logic        imem_req_valid;
   logic [31:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;

   fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
      .clk(clk), .reset(reset),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halt(halt),
      .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
      .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
      .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
   typedef struct { logic [31:0] addr; int due; } mreq_t;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // reference model: delivered-instruction queue plus counters
   ent_t        mq[$];
   logic [31:0] m_fetch = RESET_PC;
   logic [31:0] m_resp  = RESET_PC;
   int          m_inflight = 0;
   int          m_drop = 0;
   bit          m_halted = 0;

   // memory model
   mreq_t mem_q[$];
   int    lat_min = 1, lat_max = 1, ready_pct = 100, resp_pct = 100;
   bit    spurious = 0;

   logic [97:0] obs_vec, exp_vec;
   logic        o_req_fire, o_req_valid, o_resp_valid, o_inst_valid, o_pop;
   logic [31:0] o_req_addr, o_inst, o_inst_pc;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   task automatic set_mem(input int lmin, input int lmax, input int rdy, input int rsp);
      lat_min = lmin; lat_max = lmax; ready_pct = rdy; resp_pct = rsp;
   endtask

   task automatic step();
      bit          from_q, live, byp, e_req, e_ival, cmp, acc;
      logic [31:0] e_addr, e_inst, e_pc, rdata;
      ent_t        e;
      mreq_t       r;
      from_q = 0;
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
      if (!reset && mem_q.size() > 0 && mem_q[0].due <= cyc && $urandom_range(99, 0) < resp_pct) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = memfn(mem_q[0].addr);
         from_q = 1;
      end else if (spurious && (reset || mem_q.size() == 0)) begin
         imem_resp_valid = 1'b1;
         imem_resp_data  = 32'hDEADBEEF;
      end
      imem_req_ready = ($urandom_range(99, 0) < ready_pct);
      #1;
      rdata  = imem_resp_data;
      live   = !reset && imem_resp_valid && (m_inflight > 0);
      byp    = 0;
      if (BYP != 0) byp = live && (m_drop == 0) && !redirect_valid && (mq.size() == 0);
      e_req  = !reset && !m_halted && !redirect_valid && (mq.size() + m_inflight < DEPTH);
      e_addr = reset ? RESET_PC : m_fetch;
      e_ival = !reset && (mq.size() > 0 || byp);
      cmp    = reset || e_ival;
      e_inst = '0;
      e_pc   = '0;
      if (!reset && mq.size() > 0) begin
         e_inst = mq[0].data; e_pc = mq[0].pc;
      end else if (!reset && byp) begin
         e_inst = rdata; e_pc = m_resp;
      end
      exp_vec = {e_req, e_addr, e_ival, (cmp ? e_inst : 32'h0), (cmp ? e_pc : 32'h0)};
      obs_vec = {imem_req_valid, imem_req_addr, inst_valid, (cmp ? inst : 32'h0), (cmp ? inst_pc : 32'h0)};
      o_req_valid  = imem_req_valid;
      o_req_addr   = imem_req_addr;
      o_req_fire   = imem_req_valid && imem_req_ready;
      o_resp_valid = imem_resp_valid;
      o_inst_valid = inst_valid;
      o_inst       = inst;
      o_inst_pc    = inst_pc;
      o_pop        = inst_valid && inst_ready;
      acc = e_req && imem_req_ready;
      @(posedge clk);
      if (reset) begin
         mq.delete(); mem_q.delete();
         m_fetch = RESET_PC; m_resp = RESET_PC;
         m_inflight = 0; m_drop = 0; m_halted = 0;
      end else begin
         if (from_q) void'(mem_q.pop_front());
         if (o_req_fire) begin
            r.addr = o_req_addr;
            r.due  = cyc + $urandom_range(lat_max, lat_min);
            mem_q.push_back(r);
         end
         m_inflight = m_inflight + (acc ? 1 : 0) - (live ? 1 : 0);
         if (redirect_valid) begin
            mq.delete();
            m_fetch = redirect_pc; m_resp = redirect_pc;
            m_drop = m_inflight; m_halted = 0;
         end else begin
            if (acc) m_fetch = m_fetch + 32'd4;
            if (live) begin
               if (m_drop > 0) m_drop--;
               else begin
                  e.pc = m_resp; e.data = rdata;
                  mq.push_back(e);
                  m_resp = m_resp + 32'd4;
               end
            end
            if (e_ival && inst_ready) void'(mq.pop_front());
            if (halt) m_halted = 1;
         end
      end
      cyc++;
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b1; redirect_valid = 1'b0; halt = 1'b0; spurious = 0;
      step();
      step();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h200; halt = 1'b1;
      spurious = 1; inst_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         checks++;
         if (obs_vec !== {1'b0, RESET_PC, 1'b0, 64'h0}) begin
            failures++;
            $display("FAIL reset_outputs cyc=%0d got=%h want=%h", cyc, obs_vec, {1'b0, RESET_PC, 1'b0, 64'h0});
         end
      end
      reset = 1'b0; redirect_valid = 1'b0; halt = 1'b0; spurious = 0;
      step();
      checks++;
      if (o_req_valid !== 1'b1 || o_req_addr !== RESET_PC) begin
         failures++;
         $display("FAIL first_request got valid=%b addr=%h want valid=1 addr=%h", o_req_valid, o_req_addr, RESET_PC);
      end
   endtask

   task automatic test_stream();
      int first;
      bit gap;
      logic [31:0] want;
      do_reset(); set_mem(1, 1, 100, 100); inst_ready = 1'b1;
      first = -1; gap = 0; want = RESET_PC;
      for (int i = 0; i < 24; i++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL stream_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
         end
         if (o_pop) begin
            if (first < 0) first = i;
            checks++;
            if (o_inst_pc !== want || o_inst !== memfn(want)) begin
               failures++;
               $display("FAIL stream_seq got pc=%h inst=%h want pc=%h inst=%h", o_inst_pc, o_inst, want, memfn(want));
            end
            want = want + 32'd4;
         end else if (first >= 0) gap = 1;
      end
      checks++;
      if (first != 2 - BYP) begin
         failures++;
         $display("FAIL stream_first_cycle got=%0d want=%0d", first, 2 - BYP);
      end
      checks++;
      if (gap) begin
         failures++;
         $display("FAIL stream_gap got=1 want=0");
      end
   endtask

   task automatic test_backpressure();
      int nreq;
      logic [31:0] last;
      do_reset(); set_mem(1, 1, 100, 100); inst_ready = 1'b0;
      nreq = 0; last = '1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL bp_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
         end
         if (o_req_fire) begin nreq++; last = o_req_addr; end
      end
      checks++;
      if (nreq != DEPTH || last !== 32'hC || o_req_valid !== 1'b0) begin
         failures++;
         $display("FAIL bp_fill got n=%0d last=%h valid=%b want n=%0d last=0000000c valid=0", nreq, last, o_req_valid, DEPTH);
      end
      inst_ready = 1'b1;
      step();
      inst_ready = 1'b0;
      nreq = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL bp_refill_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
         end
         if (o_req_fire) begin nreq++; last = o_req_addr; end
      end
      checks++;
      if (nreq != 1 || last !== 32'h10) begin
         failures++;
         $display("FAIL bp_one_more got n=%0d addr=%h want n=1 addr=00000010", nreq, last);
      end
   endtask

   task automatic test_redirect();
      int nreq;
      bit found;
      do_reset(); set_mem(5, 5, 100, 100); inst_ready = 1'b1;
      nreq = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (o_req_fire) nreq++;
      end
      checks++;
      if (nreq != 3) begin
         failures++;
         $display("FAIL redirect_inflight got=%0d want=3", nreq);
      end
      redirect_valid = 1'b1; redirect_pc = 32'h100;
      step();
      redirect_valid = 1'b0;
      found = 0;
      for (int i = 0; i < 40 && !found; i++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL redirect_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
         end
         if (o_pop) begin
            found = 1;
            checks++;
            if (o_inst_pc !== 32'h100 || o_inst !== memfn(32'h100)) begin
               failures++;
               $display("FAIL redirect_first got pc=%h inst=%h want pc=00000100 inst=%h", o_inst_pc, o_inst, memfn(32'h100));
            end
         end
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL redirect_timeout got=none want=delivery");
      end
   endtask

   task automatic test_halt();
      int nreq, npop;
      logic [31:0] pcs[2];
      bit found;
      do_reset(); set_mem(3, 3, 100, 100); inst_ready = 1'b1;
      step();
      halt = 1'b1;
      step();
      nreq = 0; npop = 0; pcs[0] = '1; pcs[1] = '1;
      for (int i = 0; i < 10; i++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL halt_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
         end
         if (o_req_fire) nreq++;
         if (o_pop) begin
            if (npop < 2) pcs[npop] = o_inst_pc;
            npop++;
         end
      end
      checks++;
      if (nreq != 0 || npop != 2 || pcs[0] !== 32'h0 || pcs[1] !== 32'h4) begin
         failures++;
         $display("FAIL halt_drain got req=%0d pop=%0d pcs=%h,%h want req=0 pop=2 pcs=0,4", nreq, npop, pcs[0], pcs[1]);
      end
      redirect_valid = 1'b1; redirect_pc = 32'h40;
      step();
      redirect_valid = 1'b0; halt = 1'b0;
      found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL halt_resume_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
         end
         if (o_pop) begin
            found = 1;
            checks++;
            if (o_inst_pc !== 32'h40 || o_inst !== memfn(32'h40)) begin
               failures++;
               $display("FAIL halt_resume got pc=%h want pc=00000040", o_inst_pc);
            end
         end
      end
      checks++;
      if (!found) begin
         failures++;
         $display("FAIL halt_resume_timeout got=none want=delivery");
      end
   endtask

   task automatic test_wrap();
      logic [31:0] want[3];
      int n;
      want[0] = 32'hFFFFFFF8; want[1] = 32'hFFFFFFFC; want[2] = 32'h0;
      do_reset(); set_mem(1, 1, 100, 100); inst_ready = 1'b1;
      redirect_valid = 1'b1; redirect_pc = 32'hFFFFFFF8;
      step();
      redirect_valid = 1'b0;
      n = 0;
      for (int i = 0; i < 20 && n < 3; i++) begin
         step();
         if (o_pop) begin
            checks++;
            if (o_inst_pc !== want[n] || o_inst !== memfn(want[n])) begin
               failures++;
               $display("FAIL wrap_seq idx=%0d got pc=%h want pc=%h", n, o_inst_pc, want[n]);
            end
            n++;
         end
      end
      checks++;
      if (n != 3) begin
         failures++;
         $display("FAIL wrap_count got=%0d want=3", n);
      end
   endtask

   task automatic test_spurious();
      do_reset(); set_mem(1, 1, 0, 100); inst_ready = 1'b1; spurious = 1;
      for (int i = 0; i < 6; i++) begin
         step();
         checks++;
         if (obs_vec !== exp_vec || o_inst_valid !== 1'b0) begin
            failures++;
            $display("FAIL spurious cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
         end
      end
      spurious = 0;
   endtask

   task automatic test_reset_midstream();
      int t_resp, t_inst;
      do_reset(); set_mem(1, 1, 100, 100); inst_ready = 1'b0;
      for (int i = 0; i < 10; i++) step();
      reset = 1'b1; inst_ready = 1'b1;
      step();
      reset = 1'b0;
      t_resp = -1; t_inst = -1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (i == 0) begin
            checks++;
            if (o_inst_valid !== 1'b0 || o_req_valid !== 1'b1 || o_req_addr !== RESET_PC) begin
               failures++;
               $display("FAIL midreset_first got ival=%b rv=%b addr=%h want ival=0 rv=1 addr=%h", o_inst_valid, o_req_valid, o_req_addr, RESET_PC);
            end
         end
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL midreset_model cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
         end
         if (o_resp_valid && t_resp < 0) t_resp = i;
         if (o_inst_valid && t_inst < 0) t_inst = i;
      end
      checks++;
      if (t_resp < 0 || t_inst - t_resp != 1 - BYP) begin
         failures++;
         $display("FAIL midreset_latency got resp=%0d inst=%0d want gap=%0d", t_resp, t_inst, 1 - BYP);
      end
   endtask

   task automatic test_random();
      logic [31:0] rp;
      do_reset(); set_mem(1, 4, 75, 75);
      for (int i = 0; i < 3000; i++) begin
         if (i == 1500) set_mem(1, 1, 100, 100);
         inst_ready     = ($urandom_range(99, 0) < 60);
         redirect_valid = ($urandom_range(99, 0) < 4);
         rp = $urandom;
         rp[1:0] = 2'b00;
         if ($urandom_range(3, 0) == 0) rp = 32'hFFFFFFF0 | {28'h0, rp[3:2], 2'b00};
         redirect_pc = rp;
         halt     = ($urandom_range(99, 0) < 3);
         reset    = ($urandom_range(199, 0) == 0);
         spurious = ($urandom_range(99, 0) < 10);
         step();
         checks++;
         if (obs_vec !== exp_vec) begin
            failures++;
            $display("FAIL random cyc=%0d got=%h want=%h", cyc, obs_vec, exp_vec);
         end
      end
      reset = 1'b0; redirect_valid = 1'b0; halt = 1'b0; spurious = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; halt = 1'b0;
      imem_req_ready = 1'b0; imem_resp_valid = 1'b0; imem_resp_data = '0; inst_ready = 1'b0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_halt();
      test_wrap();
      test_spurious();
      test_reset_midstream();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, meaning queue entries and maximum in-flight requests; legal values are powers of two from 2 to 16.
REQ-002 The block SHALL have parameter RESET_PC, default 32'h0, meaning the first fetch address after reset.
REQ-003 Port clk, input, 1 bit: the single clock; all state changes on the rising edge.
REQ-004 Port reset, input, 1 bit: reset is synchronous and active-high.
REQ-005 Port redirect_valid, input, 1 bit: flush the block and restart fetch at redirect_pc.
REQ-006 Port redirect_pc, input, 32 bits: new fetch address, word-aligned.
REQ-007 Port halt, input, 1 bit: stop issuing new requests (ecall reached).
REQ-008 Port imem_req_valid, output, 1 bit: fetch request valid.
REQ-009 Port imem_req_addr, output, 32 bits: fetch address.
REQ-010 Port imem_req_ready, input, 1 bit: memory accepts the request this cycle.
REQ-011 Port imem_resp_valid, input, 1 bit: in-order response valid, earliest one cycle after acceptance.
REQ-012 Port imem_resp_data, input, 32 bits: instruction word.
REQ-013 Port inst_valid, output, 1 bit: instruction available to the core.
REQ-014 Port inst, output, 32 bits: instruction word at the queue head.
REQ-015 Port inst_pc, output, 32 bits: PC of inst.
REQ-016 Port inst_ready, input, 1 bit: core consumes the head this cycle.

Function
REQ-017 Request accepted when imem_req_valid && imem_req_ready; fetch_pc then advances by 4 (mod 2^32, wraps 32'hFFFFFFFC -> 0).
REQ-018 imem_req_addr SHALL equal fetch_pc at all times.
REQ-019 imem_req_valid SHALL be 1 only when state == FETCH, redirect_valid == 0, and occupancy + in_flight < DEPTH (credit rule, so the queue never overflows).
REQ-020 in_flight SHALL increment on acceptance, decrement on each imem_resp_valid, and stay unchanged when both occur in the same cycle.
REQ-021 Each non-dropped response SHALL be pushed with PC = resp_pc; resp_pc then advances by 4.
REQ-022 Pop occurs when inst_valid && inst_ready; simultaneous push and pop SHALL keep occupancy unchanged, including when full.
REQ-023 inst_valid SHALL equal (occupancy != 0); inst and inst_pc SHALL be the head entry; response-to-inst_valid latency SHALL be 1 cycle.
REQ-024 Redirect: in the cycle after redirect_valid, occupancy = 0, fetch_pc = resp_pc = redirect_pc, drop_count = in_flight (including a response arriving in the redirect cycle), in_flight keeps counting, and state = FETCH.
REQ-025 While drop_count > 0, each response SHALL be discarded and drop_count decremented; a pop in the redirect cycle SHALL have no further effect.
REQ-026 The FSM SHALL have two states, FETCH and HALTED.
REQ-027 FSM transition FETCH -> HALTED occurs on halt == 1; already queued and in-flight instructions SHALL still be delivered.
REQ-028 FSM transition HALTED -> FETCH occurs only on redirect_valid; redirect SHALL take priority over halt in the same cycle.
REQ-029 Responses with in_flight == 0 SHALL be ignored; no counter SHALL underflow.

Reset
REQ-030 While reset is high, all outputs SHALL be 0 except imem_req_addr = RESET_PC.
REQ-031 While reset is high, occupancy, in_flight and drop_count SHALL be 0, fetch_pc = resp_pc = RESET_PC, and state = FETCH.
REQ-032 Reset SHALL override redirect and halt.
REQ-033 Responses arriving while reset is high SHALL be ignored, and imem SHALL be reset by the same reset signal.
REQ-034 The first request SHALL be issued in the first cycle with reset low.

Configuration
REQ-035 With macro FETCH_QUEUE_BYPASS_EN defined, a non-dropped response arriving while occupancy == 0 SHALL appear on inst_valid/inst/inst_pc in the same cycle; if inst_ready is also 1 it SHALL be consumed without being written to the queue.
REQ-036 Without FETCH_QUEUE_BYPASS_EN, there SHALL be no combinational path from imem_resp_* to inst_*, and latency SHALL be exactly 1 cycle.

Verification
REQ-037 Scenario: reset, then memory with ready=1 and 1-cycle latency, inst_ready=1 -> inst_pc sequence 0,4,8,C..., one instruction per cycle after fill, no gaps.
REQ-038 Scenario: inst_ready=0 with DEPTH=4 -> exactly 4 requests issued (0..C), then imem_req_valid=0; on one pop a single request to 0x10 is issued.
REQ-039 Scenario: 3 requests in flight, redirect to 0x100 -> 3 responses dropped, next delivered inst_pc = 0x100 with the matching data.
REQ-040 Scenario: halt asserted with 2 in flight -> no new requests, both delivered; redirect to 0x40 -> fetch resumes at 0x40.
REQ-041 Scenario: redirect_pc = 32'hFFFFFFF8 -> inst_pc sequence FFFFFFF8, FFFFFFFC, 0.
REQ-042 Scenario: reset asserted mid-stream with full queue -> next cycle inst_valid=0; after release, first request at RESET_PC; with FETCH_QUEUE_BYPASS_EN, first inst_valid in the same cycle as the first response.
